ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester controller sharing the single-port synchronous RAM (1024 x 8, ports clk/din/addr/w_en/dout) between requesters A and B.
- Performs an optional post-reset clear of the whole array, then arbitrates read/write commands round-robin.
- Drives registered RAM control signals and returns read data with a per-requester valid strobe.
- Sits between two bus masters and the RAM instance.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 1024, number of RAM words (2**ADDR_W).
- CLEAR_ON_RESET, 1, 1 = write CLEAR_VAL to every location after reset; 0 = skip clear.
- CLEAR_VAL, 8'h00, value written during clear.

Ports:
- clk  input  1  rising-edge clock, shared with the RAM.
- rst_n  input  1  asynchronous active-low reset.
- a_req  input  1  requester A command valid.
- a_we  input  1  A command type: 1 = write, 0 = read.
- a_addr  input  ADDR_W  A address.
- a_wdata  input  DATA_W  A write data.
- a_gnt  output  1  A command accepted this cycle; combinational, depends on req and arbiter state.
- a_rvalid  output  1  A read data valid.
- a_rdata  output  DATA_W  A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B.
- ram_addr  output  ADDR_W  to RAM addr; registered.
- ram_din  output  DATA_W  to RAM din; registered.
- ram_w_en  output  1  to RAM w_en; registered.
- ram_dout  input  DATA_W  from RAM dout.
- init_done  output  1  high once the clear phase has finished.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-low, rst_n.
- Reset values:
  - ram_addr = 0, ram_din = 0, ram_w_en = 0.
  - a_gnt/b_gnt = 0, a_rvalid/b_rvalid = 0.
  - init_done = 0, clear counter = 0.
  - last_grant = B, so A wins the first tie.
  - State = INIT if CLEAR_ON_RESET = 1, else RUN.
- RAM timing: the RAM samples addr/din/w_en on a rising edge. Read data appears on ram_dout after that edge and stays stable for one cycle.
- FSM states: INIT, RUN.
- INIT:
  - Gnts are forced 0.
  - Each cycle registers ram_w_en = 1, ram_addr = cnt, ram_din = CLEAR_VAL, then cnt++.
  - After the register stage holds addr DEPTH-1: next edge drives ram_w_en = 0, sets init_done = 1, state -> RUN.
  - The clear occupies exactly DEPTH write cycles.
- RUN, arbitration (combinational each cycle):
  - Only one req high -> grant it.
  - Both high -> grant the requester other than last_grant.
  - last_grant updates only on a grant.
  - A lone requester is granted every cycle, back-to-back.
- Accept: req & gnt at edge E0.
  - At E0: ram_addr/ram_din/ram_w_en are loaded from the winner.
  - No grant -> ram_w_en = 0, and addr/din hold their values.
- Write: committed to the RAM at edge E1. No response strobe.
- Read: owner tag is pipelined two stages.
  - x_rvalid is high for the single cycle between E1 and E2.
  - x_rdata = ram_dout during that cycle. Outside that cycle rdata is don't-care; the bench must check it only when rvalid is high.
- Ordering: commands reach the RAM in grant order. A read granted the cycle after a write to the same address returns the new data.
- init_done: stays 1 until reset.
- Reset mid-operation: all in-flight reads are dropped (rvalid forced 0). FSM returns to INIT and clears again when CLEAR_ON_RESET = 1.
- No deadlock: a requester holding req waits at most one cycle under contention.

Decomposition:
- Shared package ram_ctrl_pkg:
  - ADDR_W, DATA_W, DEPTH constants.
  - State enum {INIT, RUN}.
  - Requester id type (REQ_A = 0, REQ_B = 1).
- Sub-module rr_arb2: two-input round-robin arbiter (req[1:0], accept -> gnt[1:0], last-grant flop).
- The issue register, read-tag pipeline and INIT counter stay in ram_arbiter.

Test Plan:
- Clear: CLEAR_ON_RESET = 1, CLEAR_VAL = 8'hAA, release rst_n -> init_done rises after 1024 cycles, gnts low throughout; A reads addr 788 -> a_rdata = 8'hAA.
- Single requester: A writes 210 @1010, 110 @1000, 158 @788 back-to-back, then reads 1010, 1000, 788 -> a_gnt high every cycle; a_rvalid high two cycles after each read accept with 210, 110, 158.
- Contention: A and B both hold read requests (A @1010, B @1000) for 4 cycles -> grants alternate A, B, A, B; rvalid alternates a/b with 210/110.
- Write-then-read hazard: B writes 77 @5, A reads @5 the next cycle -> a_rdata = 77.
- Reset mid-operation: assert rst_n = 0 while an A read is in flight -> a_rvalid never pulses, init_done = 0, clear restarts.
- CLEAR_ON_RESET = 0: after reset init_done = 1 at the first edge, and a lone B request is granted in the first cycle.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared constants and types for the two-requester RAM controller
// Provides RAM geometry, controller state enum and requester id type.
package ram_ctrl_pkg;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;
   typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with a last-grant flop
// Ports: clk, rst_n (async active-low), req[1:0] (bit 0 = A, bit 1 = B),
//        accept (arbitration enabled), gnt[1:0] (combinational one-hot grant).
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);
   import ram_ctrl_pkg::*;
   req_id_t last;
   // On a tie the requester that did not win last time is served.
   always_comb begin
      gnt[0] = accept & req[0] & (~req[1] | (last == REQ_B));
      gnt[1] = accept & req[1] & (~req[0] | (last == REQ_A));
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) last <= REQ_B;
      else if (|gnt) last <= gnt[1] ? REQ_B : REQ_A;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port synchronous RAM between requesters A and B
// Ports: clk, rst_n (async active-low); per requester x in {a,b}: x_req, x_we,
//        x_addr, x_wdata in, x_gnt, x_rvalid, x_rdata out; registered RAM
//        controls ram_addr/ram_din/ram_w_en, ram_dout in; init_done out.
module ram_arbiter #(
   parameter int                ADDR_W         = 10,
   parameter int                DATA_W         = 8,
   parameter int                DEPTH          = 2 ** ADDR_W,
   parameter bit                CLEAR_ON_RESET = 1'b1,
   parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_w_en,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              init_done
);
   import ram_ctrl_pkg::*;
   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [1:0]        gnt;
   logic              win_b, win_we, t1_v, t2_v;
   req_id_t           t1_id, t2_id;
   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    ({b_req, a_req}),
      .accept (state == RUN),
      .gnt    (gnt)
   );
   assign a_gnt    = gnt[0];
   assign b_gnt    = gnt[1];
   assign win_b    = gnt[1];
   assign win_we   = win_b ? b_we : a_we;
   // Read owner tag: stage 1 marks the RAM sampling edge, stage 2 the data-valid cycle.
   assign a_rvalid = t2_v & (t2_id == REQ_A);
   assign b_rvalid = t2_v & (t2_id == REQ_B);
   assign a_rdata  = ram_dout;
   assign b_rdata  = ram_dout;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= CLEAR_ON_RESET ? INIT : RUN;
         cnt       <= '0;
         init_done <= 1'b0;
         ram_addr  <= '0;
         ram_din   <= '0;
         ram_w_en  <= 1'b0;
         t1_v      <= 1'b0;
         t2_v      <= 1'b0;
         t1_id     <= REQ_A;
         t2_id     <= REQ_A;
      end else begin
         t2_v  <= t1_v;
         t2_id <= t1_id;
         if (state == INIT) begin
            t1_v <= 1'b0;
            // The last clear write is in the register stage: finish on the next edge.
            if (ram_w_en && ram_addr == ADDR_W'(DEPTH - 1)) begin
               ram_w_en  <= 1'b0;
               init_done <= 1'b1;
               state     <= RUN;
            end else begin
               ram_w_en <= 1'b1;
               ram_addr <= cnt;
               ram_din  <= CLEAR_VAL;
               cnt      <= cnt + 1'b1;
            end
         end else begin
            init_done <= 1'b1;
            ram_w_en  <= |gnt & win_we;
            t1_v      <= |gnt & ~win_we;
            t1_id     <= win_b ? REQ_B : REQ_A;
            if (|gnt) begin
               ram_addr <= win_b ? b_addr : a_addr;
               ram_din  <= win_b ? b_wdata : a_wdata;
            end
         end
      end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with behavioural RAM models
module tb_ram_arbiter;
   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int checks = 0;
   int failures = 0;
   exp_t qa[$], qb[$], q0[$];
   exp_t ea, eb, e0;
   logic [9:0] tbl_addr[3] = '{10'd1010, 10'd1000, 10'd788};
   logic [7:0] tbl_data[3] = '{8'd210, 8'd110, 8'd158};
   // clearing instance
   logic       rst_n = 1'b0;
   logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
   logic [9:0] a_addr = 0, b_addr = 0;
   logic [7:0] a_wdata = 0, b_wdata = 0;
   logic       a_gnt, a_rvalid, b_gnt, b_rvalid, ram_w_en, init_done;
   logic [7:0] a_rdata, b_rdata, ram_din, ram_dout;
   logic [9:0] ram_addr;
   logic [7:0] mem[1024];
   // non-clearing instance
   logic       rst0_n = 1'b0;
   logic       a0_req = 0, a0_we = 0, b0_req = 0, b0_we = 0;
   logic [9:0] a0_addr = 0, b0_addr = 0;
   logic [7:0] a0_wdata = 0, b0_wdata = 0;
   logic       a0_gnt, a0_rvalid, b0_gnt, b0_rvalid, ram0_w_en, init0_done;
   logic [7:0] a0_rdata, b0_rdata, ram0_din, ram0_dout;
   logic [9:0] ram0_addr;
   logic [7:0] mem0[1024];
   ram_arbiter #(.CLEAR_ON_RESET(1'b1), .CLEAR_VAL(8'hAA)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_w_en(ram_w_en),
      .ram_dout(ram_dout), .init_done(init_done)
   );
   ram_arbiter #(.CLEAR_ON_RESET(1'b0), .CLEAR_VAL(8'hAA)) dut0 (
      .clk(clk), .rst_n(rst0_n),
      .a_req(a0_req), .a_we(a0_we), .a_addr(a0_addr), .a_wdata(a0_wdata),
      .a_gnt(a0_gnt), .a_rvalid(a0_rvalid), .a_rdata(a0_rdata),
      .b_req(b0_req), .b_we(b0_we), .b_addr(b0_addr), .b_wdata(b0_wdata),
      .b_gnt(b0_gnt), .b_rvalid(b0_rvalid), .b_rdata(b0_rdata),
      .ram_addr(ram0_addr), .ram_din(ram0_din), .ram_w_en(ram0_w_en),
      .ram_dout(ram0_dout), .init_done(init0_done)
   );
   initial for (int i = 0; i < 1024; i++) begin
      mem[i]  = 8'(i) ^ 8'h5A;
      mem0[i] = 8'(i) ^ 8'h5A;
   end
   always @(posedge clk) begin
      if (ram_w_en) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
      if (ram0_w_en) mem0[ram0_addr] <= ram0_din;
      ram0_dout <= mem0[ram0_addr];
   end
   // Scoreboard: every strobe must match the oldest expectation in data and cycle.
   always @(negedge clk) begin
      if (a_rvalid) begin
         checks++;
         if (qa.size() == 0) begin
            failures++;
            $display("FAIL a_rvalid_unexpected cyc=%0d rdata=%0d required no strobe", cyc, a_rdata);
         end else begin
            ea = qa.pop_front();
            if (a_rdata !== ea.d || cyc != ea.c) begin
               failures++;
               $display("FAIL a_read got data=%0d cyc=%0d required data=%0d cyc=%0d", a_rdata, cyc, ea.d, ea.c);
            end
         end
      end
      if (b_rvalid) begin
         checks++;
         if (qb.size() == 0) begin
            failures++;
            $display("FAIL b_rvalid_unexpected cyc=%0d rdata=%0d required no strobe", cyc, b_rdata);
         end else begin
            eb = qb.pop_front();
            if (b_rdata !== eb.d || cyc != eb.c) begin
               failures++;
               $display("FAIL b_read got data=%0d cyc=%0d required data=%0d cyc=%0d", b_rdata, cyc, eb.d, eb.c);
            end
         end
      end
      if (b0_rvalid) begin
         checks++;
         if (q0.size() == 0) begin
            failures++;
            $display("FAIL b0_rvalid_unexpected cyc=%0d rdata=%0d required no strobe", cyc, b0_rdata);
         end else begin
            e0 = q0.pop_front();
            if (b0_rdata !== e0.d || cyc != e0.c) begin
               failures++;
               $display("FAIL b0_read got data=%0d cyc=%0d required data=%0d cyc=%0d", b0_rdata, cyc, e0.d, e0.c);
            end
         end
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog expired at cyc=%0d required completion", cyc);
      $fatal(1, "watchdog");
   end
   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic test_reset();
      a_req = 1; a_we = 0; a_addr = 10'd788;
      b_req = 1; b_we = 0; b_addr = 10'd1;
      wait_cycles(3);
      checks++;
      if (ram_addr !== 10'd0 || ram_din !== 8'd0 || ram_w_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_ram got addr=%0d din=%0d w_en=%b required 0 0 0", ram_addr, ram_din, ram_w_en);
      end
      checks++;
      if (a_gnt !== 1'b0 || b_gnt !== 1'b0 || a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || init_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got gnt=%b%b rvalid=%b%b init_done=%b required all 0", a_gnt, b_gnt, a_rvalid, b_rvalid, init_done);
      end
      b_req = 0;
   endtask
   task automatic test_clear(input string tag);
      int nwr = 0;
      int bad = 0;
      rst_n = 1;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (init_done) break;
         if (a_gnt !== 1'b0 || b_gnt !== 1'b0) bad++;
         if (ram_w_en) begin
            if (ram_addr !== 10'(nwr) || ram_din !== 8'hAA) bad++;
            nwr++;
         end
      end
      checks++;
      if (init_done !== 1'b1) begin
         failures++;
         $display("FAIL %s_timeout got init_done=%b required 1 within 1200 cycles", tag, init_done);
      end
      checks++;
      if (nwr != 1024 || bad != 0) begin
         failures++;
         $display("FAIL %s_writes got writes=%0d bad=%0d required 1024 0", tag, nwr, bad);
      end
      #1;
      checks++;
      if (a_gnt !== 1'b1) begin
         failures++;
         $display("FAIL %s_first_gnt got a_gnt=%b required 1", tag, a_gnt);
      end
      qa.push_back('{d: 8'hAA, c: cyc + 2});
      @(negedge clk);
      a_req = 0;
      wait_cycles(4);
   endtask
   task automatic test_single();
      a_req = 1;
      for (int i = 0; i < 6; i++) begin
         a_we = (i < 3);
         a_addr = tbl_addr[i % 3];
         a_wdata = tbl_data[i % 3];
         #1;
         checks++;
         if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin
            failures++;
            $display("FAIL single_gnt step=%0d got a=%b b=%b required 1 0", i, a_gnt, b_gnt);
         end
         if (i >= 3) qa.push_back('{d: tbl_data[i - 3], c: cyc + 2});
         @(negedge clk);
      end
      a_req = 0;
      wait_cycles(4);
   endtask
   task automatic test_contention();
      logic exp_a;
      b_req = 1; b_we = 0; b_addr = 10'd1000;
      #1;
      checks++;
      if (b_gnt !== 1'b1 || a_gnt !== 1'b0) begin
         failures++;
         $display("FAIL lone_b_gnt got a=%b b=%b required 0 1", a_gnt, b_gnt);
      end
      qb.push_back('{d: 8'd110, c: cyc + 2});
      @(negedge clk);
      a_req = 1; a_we = 0; a_addr = 10'd1010;
      for (int i = 0; i < 4; i++) begin
         exp_a = (i % 2 == 0);
         #1;
         checks++;
         if (a_gnt !== exp_a || b_gnt !== !exp_a) begin
            failures++;
            $display("FAIL contention_gnt step=%0d got a=%b b=%b required %b %b", i, a_gnt, b_gnt, exp_a, !exp_a);
         end
         if (exp_a) qa.push_back('{d: 8'd210, c: cyc + 2});
         else qb.push_back('{d: 8'd110, c: cyc + 2});
         @(negedge clk);
      end
      a_req = 0; b_req = 0;
      wait_cycles(4);
   endtask
   task automatic test_hazard();
      b_req = 1; b_we = 1; b_addr = 10'd5; b_wdata = 8'd77;
      #1;
      checks++;
      if (b_gnt !== 1'b1) begin
         failures++;
         $display("FAIL hazard_wr_gnt got b_gnt=%b required 1", b_gnt);
      end
      @(negedge clk);
      b_req = 0; a_req = 1; a_we = 0; a_addr = 10'd5;
      #1;
      checks++;
      if (a_gnt !== 1'b1) begin
         failures++;
         $display("FAIL hazard_rd_gnt got a_gnt=%b required 1", a_gnt);
      end
      qa.push_back('{d: 8'd77, c: cyc + 2});
      @(negedge clk);
      a_req = 0; b_we = 0;
      wait_cycles(4);
   endtask
   task automatic test_reset_mid();
      a_req = 1; a_we = 0; a_addr = 10'd1010;
      #1;
      checks++;
      if (a_gnt !== 1'b1) begin
         failures++;
         $display("FAIL midrst_gnt got a_gnt=%b required 1", a_gnt);
      end
      @(negedge clk);
      rst_n = 0;
      wait_cycles(3);
      checks++;
      if (init_done !== 1'b0 || ram_w_en !== 1'b0 || a_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_state got init_done=%b w_en=%b a_rvalid=%b required 0 0 0", init_done, ram_w_en, a_rvalid);
      end
      test_clear("reclear");
   endtask
   task automatic test_no_clear();
      b0_req = 1; b0_we = 0; b0_addr = 10'd3;
      wait_cycles(1);
      rst0_n = 1;
      #1;
      checks++;
      if (b0_gnt !== 1'b1 || init0_done !== 1'b0) begin
         failures++;
         $display("FAIL noclear_first got b0_gnt=%b init_done=%b required 1 0", b0_gnt, init0_done);
      end
      q0.push_back('{d: 8'h03 ^ 8'h5A, c: cyc + 2});
      @(negedge clk);
      b0_req = 0;
      checks++;
      if (init0_done !== 1'b1) begin
         failures++;
         $display("FAIL noclear_init_done got %b required 1", init0_done);
      end
      wait_cycles(4);
   endtask
   task automatic test_drain();
      checks++;
      if (qa.size() != 0 || qb.size() != 0 || q0.size() != 0) begin
         failures++;
         $display("FAIL drain got pending a=%0d b=%0d b0=%0d required 0 0 0", qa.size(), qb.size(), q0.size());
      end
   endtask
   initial begin
      @(negedge clk);
      test_reset();
      test_clear("clear");
      test_single();
      test_contention();
      test_hazard();
      test_reset_mid();
      test_no_clear();
      test_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
